text_buffer: RTL and testbench

//  Character-grid store feeding pixel_encoder: holds one ID_W-bit character id per text cell.

---
 rtl/text_buffer.sv | 252 +++++++++++++++++++++++++
 tb/tb_text_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer.sv
// text_buffer: ROWS x COLS character store with a cursor-driven write side and a registered
// display read port. Define SCROLL_EN to scroll the screen on row overflow instead of wrapping.
module text_buffer #(
   parameter int              ROWS     = 16,
   parameter int              COLS     = 32,
   parameter int              ID_W     = 8,
   parameter logic [ID_W-1:0] BLANK_ID = ID_W'(8'h20)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ID_W-1:0]           in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [$clog2(ROWS)-1:0]   char_row,
   input  logic [$clog2(COLS)-1:0]   char_col,
   output logic [ID_W-1:0]           character_id,
   output logic [$clog2(ROWS)-1:0]   cursor_row,
   output logic [$clog2(COLS)-1:0]   cursor_col,
   output logic                      busy
);

   localparam int RW    = $clog2(ROWS);
   localparam int CW    = $clog2(COLS);
   localparam int CELLS = ROWS * COLS;
   localparam int AW    = $clog2(CELLS);

   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
   localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);
`ifdef SCROLL_EN
   localparam logic [RW-1:0] SCROLL_LAST_ROW = RW'(ROWS - 2);
`endif

   localparam logic [ID_W-1:0] CODE_FF = ID_W'(8'h0C);
   localparam logic [ID_W-1:0] CODE_CR = ID_W'(8'h0D);
   localparam logic [ID_W-1:0] CODE_LF = ID_W'(8'h0A);
   localparam logic [ID_W-1:0] CODE_BS = ID_W'(8'h08);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR
`ifdef SCROLL_EN
      , SCROLL_RD,
      SCROLL_WR,
      FILL
`endif
   } state_t;

   state_t            state;
   logic [RW-1:0]     op_row;
   logic [CW-1:0]     op_col;
   logic [ID_W-1:0]   mem [CELLS];

   logic              xfer;
   logic              row_adv;
   logic              start_clear;
   logic [RW-1:0]     nxt_row;
   logic [CW-1:0]     nxt_col;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [ID_W-1:0]   wr_data;
`ifdef SCROLL_EN
   logic              start_scroll;
   logic [ID_W-1:0]   scroll_data;
`endif

   function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
      cell_addr = AW'(r) * AW'(COLS) + AW'(c);
   endfunction

   assign xfer = in_valid && in_ready;

   // Decode the accepted code into the next cursor position and a single memory write;
   // bulk states reuse the same write port with the walking op_row/op_col pointer.
   always_comb begin
      nxt_row     = cursor_row;
      nxt_col     = cursor_col;
      row_adv     = 1'b0;
      start_clear = 1'b0;
`ifdef SCROLL_EN
      start_scroll = 1'b0;
`endif
      wr_en   = 1'b0;
      wr_addr = cell_addr(op_row, op_col);
      wr_data = BLANK_ID;
      case (state)
         IDLE: begin
            if (xfer) begin
               case (in_data)
                  CODE_FF: start_clear = 1'b1;
                  CODE_CR: nxt_col = '0;
                  CODE_LF: begin
                     nxt_col = '0;
                     row_adv = 1'b1;
                  end
                  CODE_BS: begin
                     if (cursor_col != '0) begin
                        nxt_col = cursor_col - COL_ONE;
                        wr_en   = 1'b1;
                        wr_addr = cell_addr(cursor_row, cursor_col - COL_ONE);
                     end else if (cursor_row != '0) begin
                        nxt_row = cursor_row - ROW_ONE;
                        nxt_col = LAST_COL;
                        wr_en   = 1'b1;
                        wr_addr = cell_addr(cursor_row - ROW_ONE, LAST_COL);
                     end
                  end
                  default: begin
                     wr_en   = 1'b1;
                     wr_addr = cell_addr(cursor_row, cursor_col);
                     wr_data = in_data;
                     if (cursor_col == LAST_COL) begin
                        nxt_col = '0;
                        row_adv = 1'b1;
                     end else begin
                        nxt_col = cursor_col + COL_ONE;
                     end
                  end
               endcase
            end
            if (row_adv) begin
               if (cursor_row == LAST_ROW) begin
`ifdef SCROLL_EN
                  start_scroll = 1'b1;
                  nxt_row      = LAST_ROW;
`else
                  nxt_row      = '0;
`endif
               end else begin
                  nxt_row = cursor_row + ROW_ONE;
               end
            end
         end
         CLEAR: wr_en = 1'b1;
`ifdef SCROLL_EN
         SCROLL_WR: begin
            wr_en   = 1'b1;
            wr_data = scroll_data;
         end
         FILL: begin
            wr_en   = 1'b1;
            wr_addr = cell_addr(LAST_ROW, op_col);
         end
`endif
         default: ;
      endcase
      if (!rst_n) wr_en = 1'b0;
   end

   // Cell storage; the scroll path copies the cell one row below through scroll_data.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
`ifdef SCROLL_EN
      if (state == SCROLL_RD) scroll_data <= mem[cell_addr(op_row + ROW_ONE, op_col)];
`endif
   end

   // Display port: one-cycle latency, never stalled; a same-cycle write is seen next cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) character_id <= BLANK_ID;
      else        character_id <= mem[cell_addr(char_row, char_col)];
   end

   // Control FSM; in_ready and busy are registered alongside the state they describe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= CLEAR;
         op_row     <= '0;
         op_col     <= '0;
         cursor_row <= '0;
         cursor_col <= '0;
         in_ready   <= 1'b0;
         busy       <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               cursor_row <= nxt_row;
               cursor_col <= nxt_col;
               if (start_clear) begin
                  state    <= CLEAR;
                  op_row   <= '0;
                  op_col   <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
`ifdef SCROLL_EN
               if (start_scroll) begin
                  state    <= SCROLL_RD;
                  op_row   <= '0;
                  op_col   <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
`endif
            end
            CLEAR: begin
               if (op_col == LAST_COL) begin
                  op_col <= '0;
                  if (op_row == LAST_ROW) begin
                     state      <= IDLE;
                     op_row     <= '0;
                     cursor_row <= '0;
                     cursor_col <= '0;
                     in_ready   <= 1'b1;
                     busy       <= 1'b0;
                  end else begin
                     op_row <= op_row + ROW_ONE;
                  end
               end else begin
                  op_col <= op_col + COL_ONE;
               end
            end
`ifdef SCROLL_EN
            SCROLL_RD: state <= SCROLL_WR;
            SCROLL_WR: begin
               state <= SCROLL_RD;
               if (op_col == LAST_COL) begin
                  op_col <= '0;
                  if (op_row == SCROLL_LAST_ROW) begin
                     state  <= FILL;
                     op_row <= '0;
                  end else begin
                     op_row <= op_row + ROW_ONE;
                  end
               end else begin
                  op_col <= op_col + COL_ONE;
               end
            end
            FILL: begin
               if (op_col == LAST_COL) begin
                  op_col   <= '0;
                  state    <= IDLE;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
               end else begin
                  op_col <= op_col + COL_ONE;
               end
            end
`endif
            default: begin
               state    <= CLEAR;
               op_row   <= '0;
               op_col   <= '0;
               in_ready <= 1'b0;
               busy     <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_text_buffer.sv
// tb_text_buffer: directed vector table for the cursor/control codes plus hand sequences for
// reset/clear timing, read latency, stalled handshake and row overflow (wrap or SCROLL_EN).
module tb_text_buffer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] char_row;
   logic [4:0] char_col;
   logic [7:0] character_id;
   logic [3:0] cursor_row;
   logic [4:0] cursor_col;
   logic       busy;

   int total_checks = 0;
   int passed_checks = 0;

   text_buffer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .char_row     (char_row),
      .char_col     (char_col),
      .character_id (character_id),
      .cursor_row   (cursor_row),
      .cursor_col   (cursor_col),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int sr; int sc; int code; int er; int ec; int kr; int kc; int kv;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      total_checks++;
      if (actual == expected) passed_checks++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic [7:0] code);
      int n;
      n = 0;
      in_data  = code;
      in_valid = 1'b1;
      while (!in_ready && n < 2000) begin
         step();
         n++;
      end
      if (!in_ready) checkOutput("handshake_timeout", 0, 1);
      else step();
      in_valid = 1'b0;
   endtask

   task automatic waitIdle(output int n);
      n = 0;
      while (busy && n < 5000) begin
         step();
         n++;
      end
      if (busy) checkOutput("idle_timeout", 0, 1);
   endtask

   task automatic readCell(input int r, input int c, output int v);
      char_row = 4'(r);
      char_col = 5'(c);
      step();
      v = int'(character_id);
   endtask

   task automatic setCursor(input int r, input int c);
      int n;
      applyStimulus(8'h0C);
      waitIdle(n);
      for (int i = 0; i < r * 32 + c; i++) applyStimulus(8'h78);
   endtask

   initial begin
      vec_t vecs[8];
      int   n;
      int   v;
      int   bad;

      vecs[0] = '{0, 0,  'h41, 0, 1,  0, 0,  'h41};
      vecs[1] = '{2, 5,  'h0D, 2, 0,  2, 4,  'h78};
      vecs[2] = '{2, 5,  'h0A, 3, 0,  2, 5,  'h20};
      vecs[3] = '{1, 0,  'h08, 0, 31, 0, 31, 'h20};
      vecs[4] = '{0, 0,  'h08, 0, 0,  0, 0,  'h20};
      vecs[5] = '{0, 31, 'h5A, 1, 0,  0, 31, 'h5A};
      vecs[6] = '{3, 7,  'h08, 3, 6,  3, 6,  'h20};
      vecs[7] = '{5, 9,  'h0C, 0, 0,  2, 2,  'h20};

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      char_row = '0;
      char_col = '0;

      // Reset, then a full clear must take exactly ROWS*COLS clocks.
      step();
      step();
      checkOutput("reset_busy", busy, 1);
      checkOutput("reset_in_ready", in_ready, 0);
      checkOutput("reset_cursor_row", cursor_row, 0);
      checkOutput("reset_cursor_col", cursor_col, 0);
      checkOutput("reset_character_id", character_id, 'h20);
      rst_n = 1'b1;
      waitIdle(n);
      checkOutput("reset_clear_clks", n, 512);
      checkOutput("post_clear_in_ready", in_ready, 1);

      // Reset in the middle of a clear restarts it from cell 0.
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      repeat (100) step();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      waitIdle(n);
      checkOutput("midclear_reset_clks", n, 512);

      bad = 0;
      for (int i = 0; i < 512; i++) begin
         readCell(i / 32, i % 32, v);
         if (v != 'h20) bad++;
      end
      checkOutput("all_cells_blank", bad, 0);

      for (int i = 0; i < 8; i++) begin
         setCursor(vecs[i].sr, vecs[i].sc);
         applyStimulus(8'(vecs[i].code));
         waitIdle(n);
         checkOutput($sformatf("vec%0d_cursor_row", i), cursor_row, vecs[i].er);
         checkOutput($sformatf("vec%0d_cursor_col", i), cursor_col, vecs[i].ec);
         readCell(vecs[i].kr, vecs[i].kc, v);
         checkOutput($sformatf("vec%0d_cell", i), v, vecs[i].kv);
      end

      // Read latency and read-during-write: the transfer edge still shows the old cell.
      setCursor(0, 0);
      char_row = 4'd0;
      char_col = 5'd0;
      applyStimulus(8'h41);
      checkOutput("rdw_old_value", character_id, 'h20);
      checkOutput("after_41_col", cursor_col, 1);
      step();
      checkOutput("read_latency_value", character_id, 'h41);

      // in_valid held while busy must not transfer.
      applyStimulus(8'h0C);
      in_data  = 8'h41;
      in_valid = 1'b1;
      repeat (50) step();
      checkOutput("held_in_ready", in_ready, 0);
      checkOutput("held_cursor_col", cursor_col, 1);
      in_valid = 1'b0;
      waitIdle(n);
      checkOutput("held_clear_remaining", n, 462);
      checkOutput("held_end_cursor_col", cursor_col, 0);

`ifdef SCROLL_EN
      // Overflow scrolls: row1 'B' moves to row0, bottom row blanked.
      setCursor(0, 0);
      applyStimulus(8'h0A);
      for (int i = 0; i < 32; i++) applyStimulus(8'h42);
      for (int i = 0; i < 13; i++) applyStimulus(8'h0A);
      for (int i = 0; i < 31; i++) applyStimulus(8'h43);
      applyStimulus(8'h44);
      checkOutput("scroll_busy_start", busy, 1);
      waitIdle(n);
      checkOutput("scroll_clks", n, 992);
      checkOutput("scroll_cursor_row", cursor_row, 15);
      checkOutput("scroll_cursor_col", cursor_col, 0);
      readCell(0, 0, v);   checkOutput("scroll_r0c0", v, 'h42);
      readCell(0, 31, v);  checkOutput("scroll_r0c31", v, 'h42);
      readCell(1, 0, v);   checkOutput("scroll_r1c0", v, 'h20);
      readCell(14, 0, v);  checkOutput("scroll_r14c0", v, 'h43);
      readCell(14, 31, v); checkOutput("scroll_r14c31", v, 'h44);
      readCell(15, 0, v);  checkOutput("scroll_r15c0", v, 'h20);
      readCell(15, 31, v); checkOutput("scroll_r15c31", v, 'h20);
`else
      // Overflow wraps the cursor to (0,0) without touching contents or stalling.
      setCursor(0, 0);
      for (int i = 0; i < 512; i++) applyStimulus(8'(33 + (i % 90)));
      checkOutput("wrap_busy", busy, 0);
      checkOutput("wrap_cursor_row", cursor_row, 0);
      checkOutput("wrap_cursor_col", cursor_col, 0);
      readCell(15, 31, v); checkOutput("wrap_last_cell", v, 'h5E);
      readCell(0, 0, v);   checkOutput("wrap_first_cell", v, 'h21);
      readCell(7, 3, v);   checkOutput("wrap_mid_cell", v, 'h50);
`endif

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
